jzjpcc_memory_stage: RTL

Memory stage of the pipelined core, directly downstream of the execute-stage store-data/byte-mask processor. Registers the execute-stage results, performs the data-memory bus transaction with a req/ack handshake, and stalls the pipeline while it is outstanding. Extracts and sign/zero-extends load data. Presents the result, destination register and write enable to writeback.

---
 rtl/jzjpcc_pkg.sv | 30 +++
 rtl/jzjpcc_load_extractor.sv | 35 +++
 rtl/jzjpcc_memory_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jzjpcc_pkg.sv
// Shared definitions for the jzjpcc pipeline: load funct3 encodings,
// the memory-stage state enum and the memory-stage pipeline register layout.
package jzjpcc_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memStageState_t;

  // Everything the memory stage needs from execute. Load-vs-store is
  // carried by memWrite alone; a set memRead only matters at capture time,
  // where it decides whether a bus access is started.
  typedef struct packed {
    logic        valid;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic [3:0]  byteMask;
    logic [4:0]  rdAddress;
    logic        regWrite;
  } stageReg_t;

endpackage

// File: rtl/jzjpcc_load_extractor.sv
// Picks the addressed byte/halfword out of a bus word and sign- or
// zero-extends it according to the load funct3. Unknown encodings act as LW.
module jzjpcc_load_extractor
  import jzjpcc_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOffset,
  input  logic [31:0] rdata,
  output logic [31:0] loadValue
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  // Lane selection followed by width/sign extension.
  always_comb begin
    selByte   = rdata[7:0];
    selHalf   = byteOffset[1] ? rdata[31:16] : rdata[15:0];
    loadValue = rdata;
    case (byteOffset)
      2'd0:    selByte = rdata[7:0];
      2'd1:    selByte = rdata[15:8];
      2'd2:    selByte = rdata[23:16];
      default: selByte = rdata[31:24];
    endcase
    case (funct3)
      LB:      loadValue = {{24{selByte[7]}}, selByte};
      LBU:     loadValue = {24'b0, selByte};
      LH:      loadValue = {{16{selHalf[15]}}, selHalf};
      LHU:     loadValue = {16'b0, selHalf};
      default: loadValue = rdata;
    endcase
  end

endmodule

// File: rtl/jzjpcc_memory_stage.sv
// Memory stage: registers execute results, runs the req/ack data-bus access
// (stalling upstream while it is outstanding, abandoning it after
// ACK_TIMEOUT cycles) and presents result/rd/regWrite to writeback.
module jzjpcc_memory_stage
  import jzjpcc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_execute,
  input  logic        memRead_execute,
  input  logic        memWrite_execute,
  input  logic [2:0]  funct3_execute,
  input  logic [31:0] aluResult_execute,
  input  logic [31:0] memDataToWrite_execute,
  input  logic [3:0]  memByteMask_execute,
  input  logic [4:0]  rdAddress_execute,
  input  logic        regWrite_execute,
  output logic        stall_memory,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteMask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] result_memory,
  output logic [4:0]  rdAddress_memory,
  output logic        regWrite_memory,
  output logic        valid_memory,
  output logic        busFault_memory
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);

  memStageState_t state;
  stageReg_t      stage;
  logic [CW-1:0]  waitCount;
  logic           inAccess;
  logic           timeoutHit;
  logic           captureMem;
  logic [31:0]    loadValue;

  assign inAccess     = (state == ACCESS);
  assign timeoutHit   = inAccess & ~bus_ack & (waitCount == TIMEOUT_LAST);
  assign stall_memory = inAccess & ~bus_ack & ~timeoutHit;
  assign captureMem   = valid_execute & (memRead_execute | memWrite_execute);

  jzjpcc_load_extractor u_extractor (
    .funct3     (stage.funct3),
    .byteOffset (stage.aluResult[1:0]),
    .rdata      (bus_rdata),
    .loadValue  (loadValue)
  );

  // Bus outputs come straight from the stage register so they stay stable
  // for the whole access; everything is quiet outside an access.
  always_comb begin
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;
    bus_byteMask = '0;
    if (inAccess) begin
      bus_req      = 1'b1;
      bus_we       = stage.memWrite;
      bus_addr     = {stage.aluResult[31:2], 2'b00};
      bus_wdata    = stage.storeData;
      bus_byteMask = stage.memWrite ? stage.byteMask : 4'hF;
    end
  end

  // Stage register: takes the next execute instruction whenever not stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage <= '0;
    end else if (!stall_memory) begin
      stage.valid     <= valid_execute;
      stage.memWrite  <= memWrite_execute;
      stage.funct3    <= funct3_execute;
      stage.aluResult <= aluResult_execute;
      stage.storeData <= memDataToWrite_execute;
      stage.byteMask  <= memByteMask_execute;
      stage.rdAddress <= rdAddress_execute;
      stage.regWrite  <= valid_execute & regWrite_execute;
    end
  end

  // Access FSM and wait counter; the counter is zero on entry to ACCESS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      waitCount <= '0;
    end else if (stall_memory) begin
      waitCount <= waitCount + CW'(1);
    end else begin
      waitCount <= '0;
      state     <= captureMem ? ACCESS : IDLE;
    end
  end

  // Writeback registers: retire a completed, abandoned or non-memory op.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_memory    <= '0;
      rdAddress_memory <= '0;
      regWrite_memory  <= 1'b0;
      valid_memory     <= 1'b0;
      busFault_memory  <= 1'b0;
    end else begin
      busFault_memory <= 1'b0;
      if (inAccess) begin
        if (bus_ack) begin
          valid_memory     <= 1'b1;
          rdAddress_memory <= stage.rdAddress;
          regWrite_memory  <= stage.regWrite & ~stage.memWrite;
          result_memory    <= stage.memWrite ? 32'h0 : loadValue;
        end else if (timeoutHit) begin
          valid_memory     <= 1'b1;
          rdAddress_memory <= stage.rdAddress;
          regWrite_memory  <= 1'b0;
          result_memory    <= 32'h0;
          busFault_memory  <= 1'b1;
        end else begin
          valid_memory    <= 1'b0;
          regWrite_memory <= 1'b0;
        end
      end else if (stage.valid) begin
        valid_memory     <= 1'b1;
        rdAddress_memory <= stage.rdAddress;
        regWrite_memory  <= stage.regWrite;
        result_memory    <= stage.aluResult;
      end else begin
        valid_memory    <= 1'b0;
        regWrite_memory <= 1'b0;
      end
    end
  end

endmodule
